// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between execute and the RAM port: lane generation, fixed-latency access, load alignment.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_bridge #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    output logic        mem_write_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_mask,
    input  logic [31:0] mem_read_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;
    logic             req_ready_q, req_ready_d;
    logic             mem_valid_q, mem_valid_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_mask_q, mem_mask_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_error_q, resp_error_d;
    logic             req_err_c;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] rd);
        logic [1:0]  o;
        logic [31:0] s;
        o = (size == 2'b00) ? off : (size == 2'b01) ? {off[1], 1'b0} : 2'b00;
        s = rd >> {o, 3'b000};
        case (size)
            2'b00:   return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
            2'b01:   return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Requests rejected before any memory access
    always_comb begin
        req_err_c = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00))
            req_err_c = 1'b1;
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        mem_valid_d  = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = 32'h0;
        mem_wdata_d  = 32'h0;
        mem_mask_d   = 4'h0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    off_d       = req_addr[1:0];
                    req_ready_d = 1'b0;
                    if (req_err_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = CNT_INIT;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_we_d    = req_write && (MEM_LATENCY == 1);
                        if (req_write) begin
                            mem_wdata_d = lane_data(req_size, req_wdata);
                            mem_mask_d  = lane_mask(req_size, req_addr[1:0]);
                        end
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Final access cycle: read word is sampled here
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = write_q ? 32'h0 : load_align(size_q, uns_q, off_q, mem_read_data);
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    mem_valid_d = 1'b1;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                    mem_mask_d  = mem_mask_q;
                    mem_we_d    = write_q && (cnt_q == CNT_W'(1));
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_error_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            req_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_mask_q   <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign mem_valid        = mem_valid_q;
    assign mem_write_enable = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_write_data   = mem_wdata_q;
    assign mem_write_mask   = mem_mask_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_error       = resp_error_q;

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Load/store unit sitting directly upstream of the DPI-backed RAM port.
- Accepts one load or store from the execute stage over a valid/ready handshake.
- Generates the word-aligned address, write data and byte mask for the RAM, holds the access for a configurable latency, then aligns and extends load data.
- Returns the result over a second valid/ready handshake to writeback.

Parameters:
- MEM_LATENCY, 1, cycles mem_valid is held per access; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- mem_valid  out  1  RAM access active.
- mem_write_enable  out  1  RAM write strobe.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_write_data  out  32  lane-replicated store data.
- mem_write_mask  out  4  byte-lane mask.
- mem_read_data  in  32  RAM read word, combinational from mem_addr.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  aligned, extended load data; 0 for stores and errors.
- resp_error  out  1  request rejected; no memory access was made.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (reset==0 at a clock edge), from any state, including mid-ACCESS or RESP:
  - state goes to IDLE; any in-flight request is dropped.
  - All outputs 0 except req_ready=1.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch write, size, unsigned, addr and wdata.
  - Go to RESP with error=1 if size==11, or if misaligned and the optional feature is enabled. Otherwise load the counter with MEM_LATENCY-1 and go to ACCESS.
- ACCESS:
  - mem_valid=1 and mem_addr driven every cycle.
  - Counter decrements each cycle; the final cycle is when the counter reaches 0.
  - mem_write_enable=1 only on the final cycle and only for stores (exactly one write per store).
  - Loads: mem_read_data is sampled on the final cycle.
  - Go to RESP after the final cycle.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are stable until handshake.
  - On resp_ready, go to IDLE.
  - req_ready=0 throughout; no request overlap.
- Latency: request accepted at edge T; mem_valid high for cycles T+1..T+MEM_LATENCY; resp_valid first high at cycle T+MEM_LATENCY+1. Error path: resp_valid at T+1.
- Throughput: one request per MEM_LATENCY+2 cycles when resp_ready is held high.
- Outputs outside ACCESS: mem_valid, mem_write_enable, mem_write_data and mem_write_mask are 0.
- Store lanes (o = addr[1:0]):
  - byte: mask = 4'b0001<<o, data = {4{wdata[7:0]}}.
  - half: mask = 4'b0011<<{o[1],1'b0}, data = {2{wdata[15:0]}}.
  - word: mask = 4'b1111, data = wdata.
- Load alignment:
  - shifted = read_data >> (8*o), with o[0] forced to 0 for halves and o forced to 00 for words.
  - byte/half are sign- or zero-extended to 32 bits per the latched unsigned flag.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a half with addr[0]=1, or a word with addr[1:0]!=0, goes IDLE->RESP with resp_error=1, resp_rdata=0 and no mem_valid pulse.
- Undefined: misaligned accesses proceed, ignoring the offending low bits as in the lane rules; resp_error is set only for size==11.

Test Plan:
- Store byte, addr 0x80000003, wdata 0x000000AB, MEM_LATENCY=1 -> one cycle with mem_valid=1, mem_write_enable=1, mem_addr 0x80000000, mask 4'b1000, mem_write_data 0xABABABAB; resp_valid next cycle, resp_rdata 0.
- Signed byte load, addr 0x80000001, mem_read_data 0x12348056 -> resp_rdata 0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
- Signed half load, addr 0x80000002, mem_read_data 0xBEEF1234, MEM_LATENCY=3 -> mem_valid high exactly 3 cycles, resp_valid at T+4, resp_rdata 0xFFFFBEEF.
- Word load, addr 0x80000002:
  - with LSU_MISALIGN_TRAP_EN -> resp_error=1 at T+1, mem_valid never high.
  - without it -> mem_addr 0x80000000, resp_rdata = mem_read_data.
- resp_ready held 0 for 3 cycles after resp_valid -> resp_valid, resp_rdata and resp_error stable, req_ready=0, a new req_valid is not accepted; accepted the cycle after resp_ready=1.
- Reset asserted (0) during ACCESS of a store with MEM_LATENCY=4 -> next cycle state IDLE, req_ready=1, mem_write_enable never pulsed, no resp_valid.
